// File: rtl/dmem_loader.sv
// Boot loader: turns a length-prefixed little-endian byte stream into data-memory word writes
// and holds the core in reset until the image is in. Optional checksum: DMEM_LOADER_CHECKSUM_EN.
module dmem_loader #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              err
);

`ifdef DMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      StIdle, StLen0, StLen1, StData, StWrite, StDone, StErr, StChk
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle, StLen0, StLen1, StData, StWrite, StDone, StErr
   } state_e;
`endif

   state_e            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [23:0]       word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [15:0]       full_len;
   logic              accept;
`ifdef DMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   assign accept    = in_valid && in_ready;
   assign full_len  = {in_data, len_q[7:0]};
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   // Handshake and status are pure decodes of the state register.
   always_comb begin
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      core_hold = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      case (state_q)
         StLen0, StLen1, StData: in_ready = 1'b1;
`ifdef DMEM_LOADER_CHECKSUM_EN
         StChk:                  in_ready = 1'b1;
`endif
         StWrite:                mem_we = 1'b1;
         StDone: begin
            core_hold = 1'b0;
            done      = 1'b1;
         end
         StErr:                  err = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      word_d  = word_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef DMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
      if (accept && state_q != StChk) csum_d = csum_q ^ in_data;
`endif
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StLen0;
`ifdef DMEM_LOADER_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
            end
         end
         StLen0: begin
            if (accept) begin
               len_d[7:0] = in_data;
               state_d    = StLen1;
            end
         end
         StLen1: begin
            if (accept) begin
               len_d  = full_len;
               cnt_d  = 16'd0;
               addr_d = '0;
               idx_d  = 2'd0;
               if (full_len == 16'd0) begin
`ifdef DMEM_LOADER_CHECKSUM_EN
                  state_d = StChk;
`else
                  state_d = StDone;
`endif
               end else if (32'(full_len) > DEPTH) begin
                  state_d = StErr;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0: word_d[7:0]   = in_data;
                  2'd1: word_d[15:8]  = in_data;
                  2'd2: word_d[23:16] = in_data;
                  default: begin
                     wdata_d = {in_data, word_q};
                     state_d = StWrite;
                  end
               endcase
            end
         end
         StWrite: begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 16'd1;
            if (cnt_d == len_q) begin
`ifdef DMEM_LOADER_CHECKSUM_EN
               state_d = StChk;
`else
               state_d = StDone;
`endif
            end else begin
               state_d = StData;
            end
         end
`ifdef DMEM_LOADER_CHECKSUM_EN
         StChk: begin
            if (accept) state_d = (in_data == csum_q) ? StDone : StErr;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         len_q   <= 16'd0;
         cnt_q   <= 16'd0;
         idx_q   <= 2'd0;
         word_q  <= 24'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
`ifdef DMEM_LOADER_CHECKSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef DMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

endmodule
